// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution window scheduler: default geometry,
// derived output size, the window tag carried through the pipeline and FIFO, and FSM states.
package conv_pkg;

    localparam int IMG_DIM = 5;
    localparam int FLT_DIM = 3;
    localparam int STRIDE  = 1;
    localparam int RES_W   = 12;

    localparam int OUT_DIM = (IMG_DIM - FLT_DIM) / STRIDE + 1;
    localparam int NWIN    = OUT_DIM * OUT_DIM;
    localparam int IDX_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic             last;
    } win_tag_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } sched_state_e;

endpackage

// File: rtl/conv_res_fifo.sv
// First-word-fall-through result FIFO carrying {data, win_tag_t}; async active-high reset.
// Head data/tag read as zero while empty so downstream sees clean idle outputs.
module conv_res_fifo import conv_pkg::*; #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  win_tag_t                     push_tag,
    input  logic                         pop,
    output logic [DATA_W-1:0]            pop_data,
    output win_tag_t                     pop_tag,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        win_tag_t          tag;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push while full is accepted then.
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= '{data: push_data, tag: push_tag};
    end

    always_comb begin
        pop_data = '0;
        pop_tag  = '0;
        if (!empty) begin
            pop_data = mem[rd_ptr_q].data;
            pop_tag  = mem[rd_ptr_q].tag;
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Issues window origins in raster order to a fixed-latency datapath, captures results into a
// credit-protected FIFO and streams them out. Define CONV_SCHED_RELU_EN to clamp negatives at capture.
module conv_window_scheduler import conv_pkg::*; #(
    parameter int   IMG_DIM    = conv_pkg::IMG_DIM,
    parameter int   FLT_DIM    = conv_pkg::FLT_DIM,
    parameter int   STRIDE     = conv_pkg::STRIDE,
    parameter int   PIPE_LAT   = 3,
    parameter int   RES_W      = conv_pkg::RES_W,
    parameter int   FIFO_DEPTH = 4,
    localparam int  OUT_DIM    = (IMG_DIM - FLT_DIM) / STRIDE + 1,
    localparam int  IDX_W      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1,
    localparam int  BASE_W     = $clog2(IMG_DIM * IMG_DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              issue_valid,
    output logic [IDX_W-1:0]  win_row,
    output logic [IDX_W-1:0]  win_col,
    output logic [BASE_W-1:0] win_base,
    input  logic [RES_W-1:0]  res_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_col,
    output logic              out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  row_q, col_q;
    logic [BASE_W-1:0] base_q, row_base_q;
    logic [CNT_W-1:0]  inflight_q, fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              has_credit, last_win, clear, issue, pop, capture, fifo_empty;

    logic [PIPE_LAT-1:0]            sr_valid_q;
    logic [PIPE_LAT-1:0][IDX_W-1:0] sr_row_q, sr_col_q;

    win_tag_t          cap_tag, out_tag;
    logic [RES_W-1:0]  cap_data;

    assign pop       = out_valid && out_ready;
    // Slot freed by this cycle's pop is reusable now, which sustains one issue per cycle.
    assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight_q} - (CNT_W+1)'(pop);
    assign has_credit = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign last_win   = (row_q == IDX_W'(OUT_DIM - 1)) && (col_q == IDX_W'(OUT_DIM - 1));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done    = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    clear   = 1'b1;
                end
            end
            StRun: begin
                issue = has_credit;
                if (has_credit && last_win) state_d = StDrain;
            end
            StDrain: begin
                if (inflight_q == '0 && fifo_empty) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign issue_valid = issue;
    assign win_row     = row_q;
    assign win_col     = col_q;
    assign win_base    = base_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            base_q     <= '0;
            row_base_q <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                row_q      <= '0;
                col_q      <= '0;
                base_q     <= '0;
                row_base_q <= '0;
            end else if (issue) begin
                if (col_q == IDX_W'(OUT_DIM - 1)) begin
                    col_q <= '0;
                    if (row_q == IDX_W'(OUT_DIM - 1)) begin
                        row_q      <= '0;
                        row_base_q <= '0;
                        base_q     <= '0;
                    end else begin
                        row_q      <= row_q + 1'b1;
                        row_base_q <= row_base_q + BASE_W'(STRIDE * IMG_DIM);
                        base_q     <= row_base_q + BASE_W'(STRIDE * IMG_DIM);
                    end
                end else begin
                    col_q  <= col_q + 1'b1;
                    base_q <= base_q + BASE_W'(STRIDE);
                end
            end
        end
    end

    // Tag pipeline mirrors the datapath latency; it never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_valid_q <= '0;
            sr_row_q   <= '0;
            sr_col_q   <= '0;
            inflight_q <= '0;
        end else begin
            sr_valid_q[0] <= issue;
            sr_row_q[0]   <= row_q;
            sr_col_q[0]   <= col_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                sr_valid_q[i] <= sr_valid_q[i-1];
                sr_row_q[i]   <= sr_row_q[i-1];
                sr_col_q[i]   <= sr_col_q[i-1];
            end
            inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(capture);
        end
    end

    assign capture = sr_valid_q[PIPE_LAT-1];

    always_comb begin
        cap_tag      = '0;
        cap_tag.row  = sr_row_q[PIPE_LAT-1];
        cap_tag.col  = sr_col_q[PIPE_LAT-1];
        cap_tag.last = (sr_row_q[PIPE_LAT-1] == IDX_W'(OUT_DIM - 1)) &&
                       (sr_col_q[PIPE_LAT-1] == IDX_W'(OUT_DIM - 1));
    end

`ifdef CONV_SCHED_RELU_EN
    assign cap_data = res_in[RES_W-1] ? '0 : res_in;
`else
    assign cap_data = res_in;
`endif

    conv_res_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (RES_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (cap_data),
        .push_tag  (cap_tag),
        .pop       (pop),
        .pop_data  (out_data),
        .pop_tag   (out_tag),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_row   = out_tag.row;
    assign out_col   = out_tag.col;
    assign out_last  = out_tag.last;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler: models the fixed-latency datapath (res_in = base-6)
// and checks issue order, output order/data/tags, latency, backpressure and done behaviour.
module tb_conv_window_scheduler;
    import conv_pkg::*;

    localparam int PIPE_LAT   = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int BASE_W     = $clog2(IMG_DIM * IMG_DIM);

    logic              clk = 1'b0;
    logic              rst, start, out_ready;
    logic              busy, done, issue_valid, out_valid, out_last;
    logic [IDX_W-1:0]  win_row, win_col, out_row, out_col;
    logic [BASE_W-1:0] win_base;
    logic [RES_W-1:0]  res_in, out_data;

    conv_window_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .issue_valid (issue_valid),
        .win_row     (win_row),
        .win_col     (win_col),
        .win_base    (win_base),
        .res_in      (res_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
        int last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0, bad = 0;
    int   cyc = 0, start_cyc = 0, last_hs = 0;
    int   iss_idx = 0, out_idx = 0, frames_done = 0;
    int   rdy_mode = 0;
    bit   chk_lat = 1'b0;
    bit   dp_v [3];
    int   dp_d [3];
    int   r, c, b, d;
    logic [RES_W-1:0] noise = 12'h5A5;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq(tag, int'({busy, done, issue_valid, win_row, win_col, win_base, out_valid,
                            out_data, out_row, out_col, out_last}), 0);
    endtask

    task automatic frame_start();
        start     = 1'b1;
        start_cyc = cyc;
        step(1);
        start = 1'b0;
        check_eq("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            step(1);
            n++;
        end
        check_eq("frame_done", frames_done, target);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Datapath model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            iss_idx = 0;
            out_idx = 0;
            for (int i = 0; i < 3; i++) begin
                dp_v[i] = 1'b0;
                dp_d[i] = 0;
            end
            res_in = '0;
        end else begin
            res_in  = dp_v[2] ? RES_W'(dp_d[2]) : noise;
            dp_v[2] = dp_v[1];
            dp_d[2] = dp_d[1];
            dp_v[1] = dp_v[0];
            dp_d[1] = dp_d[0];
            dp_v[0] = issue_valid;
            dp_d[0] = int'(win_base) - 6;

            if (issue_valid) begin
                check_eq("iss_in_frame", int'(iss_idx < NWIN), 1);
                r = iss_idx / OUT_DIM;
                c = iss_idx % OUT_DIM;
                b = r * STRIDE * IMG_DIM + c * STRIDE;
                d = b - 6;
`ifdef CONV_SCHED_RELU_EN
                if (d < 0) d = 0;
`endif
                check_eq("win_row", int'(win_row), r);
                check_eq("win_col", int'(win_col), c);
                check_eq("win_base", int'(win_base), b);
                if (chk_lat) check_eq("iss_cycle", cyc - start_cyc, 1 + iss_idx);
                q.push_back('{row: r, col: c, data: d,
                              last: int'(r == OUT_DIM - 1 && c == OUT_DIM - 1)});
                iss_idx++;
            end

            if (out_valid && out_ready) begin
                check_eq("out_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check_eq("out_data", int'($signed(out_data)), e.data);
                    check_eq("out_row", int'(out_row), e.row);
                    check_eq("out_col", int'(out_col), e.col);
                    check_eq("out_last", int'(out_last), e.last);
                end
                if (chk_lat) check_eq("out_cycle", cyc - start_cyc, PIPE_LAT + 2 + out_idx);
                last_hs = cyc;
                out_idx++;
            end

            if (issue_valid) check_eq("occupancy", int'(iss_idx - out_idx <= FIFO_DEPTH), 1);

            if (done) begin
                check_eq("done_count", out_idx, NWIN);
                check_eq("done_q_empty", q.size(), 0);
                check_eq("done_delay", cyc - last_hs, 1);
                frames_done++;
                iss_idx = 0;
                out_idx = 0;
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_zero("reset_outputs");
        step(2);
        rst = 1'b0;
        step(2);

        // Full-rate frame: issue timing, data, tags, latency.
        chk_lat  = 1'b1;
        rdy_mode = 0;
        frame_start();
        wait_frames(1, 100);
        check_eq("idle_after_frame", int'(busy), 0);

        // Stalled consumer: only FIFO_DEPTH issues until released.
        chk_lat  = 1'b0;
        rdy_mode = 1;
        frame_start();
        step(20);
        check_eq("stall_issues", iss_idx, FIFO_DEPTH);
        check_eq("stall_issue_low", int'(issue_valid), 0);
        rdy_mode = 0;
        wait_frames(2, 100);

        // Random backpressure across 20 frames.
        rdy_mode = 2;
        for (int f = 0; f < 20; f++) begin
            frame_start();
            wait_frames(3 + f, 400);
        end

        // start while busy is ignored.
        rdy_mode = 0;
        frame_start();
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_frames(23, 100);
        step(10);
        check_eq("busy_start_ignored", int'(busy), 0);
        check_eq("busy_frames", frames_done, 23);

        // Reset in the middle of RUN, then a clean frame.
        frame_start();
        step(4);
        rst = 1'b1;
        #1;
        check_zero("midrun_reset_outputs");
        step(1);
        rst = 1'b0;
        step(6);
        check_eq("no_done_after_reset", frames_done, 23);
        check_eq("idle_after_reset", int'(busy), 0);
        chk_lat = 1'b1;
        frame_start();
        wait_frames(24, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
